// File: rtl/fifo_enq_arbiter.sv
// Two-requester arbiter in front of one shared FIFO enqueue port. Grants are
// bursts of up to BURST beats. Define FIFO_ENQ_ARB_STATS_EN to add per-requester beat counters.
module fifo_enq_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0,
  input  logic             req1,
  input  logic             enq0__ENA,
  input  logic             enq1__ENA,
  input  logic [WIDTH-1:0] enq0_v,
  input  logic [WIDTH-1:0] enq1_v,
  output logic             enq0__RDY,
  output logic             enq1__RDY,
  output logic             fifo_enq__ENA,
  output logic [WIDTH-1:0] fifo_enq_v,
  input  logic             fifo_enq__RDY,
  output logic [1:0]       owner
`ifdef FIFO_ENQ_ARB_STATS_EN
  ,
  output logic [31:0]      beats0,
  output logic [31:0]      beats1
`endif
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;
  localparam logic [3:0] BURST_LIM = 4'(BURST);

  logic [1:0] state_q, state_d;
  logic [3:0] bc_q, bc_d;
  logic       lp_q, lp_d;

  logic       beat0, beat1, beat;
  logic       own_req, other_req;
  logic [3:0] bc_inc;
  logic       release_grant;

  // Ready never looks at any ENA input, so a requester can't create a comb loop.
  assign enq0__RDY     = (state_q == OWN0) && fifo_enq__RDY;
  assign enq1__RDY     = (state_q == OWN1) && fifo_enq__RDY;
  assign beat0         = enq0__ENA && enq0__RDY;
  assign beat1         = enq1__ENA && enq1__RDY;
  assign beat          = beat0 || beat1;
  assign fifo_enq__ENA = beat;
  assign fifo_enq_v    = beat0 ? enq0_v : (beat1 ? enq1_v : '0);
  assign owner         = state_q;

  assign own_req       = (state_q == OWN1) ? req1 : req0;
  assign other_req     = (state_q == OWN1) ? req0 : req1;
  assign bc_inc        = bc_q + 4'd1;
  assign release_grant = (beat && (bc_inc == BURST_LIM)) || (!own_req && !beat);

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    lp_d    = lp_q;
    case (state_q)
      IDLE: begin
        // On a tie, grant the requester that was not served last.
        if (req0 && (!req1 || lp_q)) begin
          state_d = OWN0;
          bc_d    = 4'd0;
          lp_d    = 1'b0;
        end else if (req1) begin
          state_d = OWN1;
          bc_d    = 4'd0;
          lp_d    = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (beat) bc_d = bc_inc;
        if (release_grant) begin
          bc_d = 4'd0;
          if (other_req) begin
            state_d = (state_q == OWN0) ? OWN1 : OWN0;
            lp_d    = (state_q == OWN0);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        bc_d    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      bc_q    <= 4'd0;
      lp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      lp_q    <= lp_d;
    end
  end

`ifdef FIFO_ENQ_ARB_STATS_EN
  logic [31:0] beats0_q, beats1_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      beats0_q <= 32'd0;
      beats1_q <= 32'd0;
    end else begin
      if (beat0) beats0_q <= beats0_q + 32'd1;
      if (beat1) beats1_q <= beats1_q + 32'd1;
    end
  end

  assign beats0 = beats0_q;
  assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: directed scenarios followed by random traffic,
// all checked against a grant/burst reference model.
module tb_fifo_enq_arbiter;

  localparam int W = 32;
  localparam int B = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic         enq0__ENA = 1'b0, enq1__ENA = 1'b0;
  logic [W-1:0] enq0_v = '0, enq1_v = '0;
  logic         enq0__RDY, enq1__RDY;
  logic         fifo_enq__ENA;
  logic [W-1:0] fifo_enq_v;
  logic         fifo_enq__RDY = 1'b1;
  logic [1:0]   owner;
`ifdef FIFO_ENQ_ARB_STATS_EN
  logic [31:0]  beats0, beats1;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the port, beats in this grant, last served.
  int          m_own;
  int          m_cnt;
  int          m_last;
  int unsigned m_b0, m_b1;

  fifo_enq_arbiter #(.WIDTH(W), .BURST(B)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1),
    .enq0__ENA(enq0__ENA), .enq1__ENA(enq1__ENA),
    .enq0_v(enq0_v), .enq1_v(enq1_v),
    .enq0__RDY(enq0__RDY), .enq1__RDY(enq1__RDY),
    .fifo_enq__ENA(fifo_enq__ENA), .fifo_enq_v(fifo_enq_v),
    .fifo_enq__RDY(fifo_enq__RDY),
    .owner(owner)
`ifdef FIFO_ENQ_ARB_STATS_EN
    , .beats0(beats0), .beats1(beats1)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_cnt  = 0;
    m_last = 1;
    m_b0   = 0;
    m_b1   = 0;
  endtask

  // Asserts reset mid-cycle, checks outputs are forced low immediately, then releases it.
  task automatic do_reset(input string tag);
    RST = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rdy0"},  enq0__RDY, 1'b0);
    chk({tag, ".rdy1"},  enq1__RDY, 1'b0);
    chk({tag, ".fena"},  fifo_enq__ENA, 1'b0);
    chk({tag, ".fv"},    fifo_enq_v, '0);
    chk({tag, ".owner"}, owner, 2'b00);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One cycle: drive at negedge, check, take the rising edge, advance the model.
  task automatic step(input logic r0, input logic r1, input logic e0, input logic e1,
                      input logic fr, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input string tag);
    logic         x_rdy0, x_rdy1, b0, b1, bt, own_r, oth_r, rel;
    logic [W-1:0] x_v;
    logic [1:0]   x_own;
    req0 = r0; req1 = r1; enq0__ENA = e0; enq1__ENA = e1;
    fifo_enq__RDY = fr; enq0_v = d0; enq1_v = d1;
    #1;
    x_rdy0 = (m_own == 0) && fr;
    x_rdy1 = (m_own == 1) && fr;
    b0 = e0 && x_rdy0;
    b1 = e1 && x_rdy1;
    bt = b0 || b1;
    x_v = b0 ? d0 : (b1 ? d1 : '0);
    x_own = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    chk({tag, ".owner"}, owner, x_own);
    chk({tag, ".rdy0"}, enq0__RDY, x_rdy0);
    chk({tag, ".rdy1"}, enq1__RDY, x_rdy1);
    chk({tag, ".fena"}, fifo_enq__ENA, bt);
    chk({tag, ".fv"}, fifo_enq_v, x_v);
`ifdef FIFO_ENQ_ARB_STATS_EN
    chk({tag, ".beats0"}, beats0, m_b0);
    chk({tag, ".beats1"}, beats1, m_b1);
`endif
    @(posedge CLK);
    if (b0) m_b0++;
    if (b1) m_b1++;
    if (m_own < 0) begin
      if (r0 && r1) m_own = (m_last == 0) ? 1 : 0;
      else if (r0)  m_own = 0;
      else if (r1)  m_own = 1;
      if (m_own >= 0) begin
        m_cnt  = 0;
        m_last = m_own;
      end
    end else begin
      own_r = (m_own == 0) ? r0 : r1;
      oth_r = (m_own == 0) ? r1 : r0;
      if (bt) m_cnt++;
      rel = (bt && m_cnt == B) || (!own_r && !bt);
      if (rel) begin
        m_cnt = 0;
        if (oth_r) begin
          m_own  = 1 - m_own;
          m_last = m_own;
        end else begin
          m_own = -1;
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    model_reset();
    req0 = 1'b1; req1 = 1'b1; enq0__ENA = 1'b1; enq1__ENA = 1'b1;
    enq0_v = 32'h1111_1111; enq1_v = 32'h2222_2222;
    @(negedge CLK);
    do_reset("rst");

    // Both requesters streaming: alternating 4-beat bursts, no idle gap.
    for (int i = 0; i < 20; i++)
      step(1, 1, 1, 1, 1, $urandom, $urandom, "stream");
    chk("stream.owner_end", owner, (m_own == 0) ? 2'b01 : 2'b10);

    do_reset("rst2");
    // Single beat from requester 1, then it drops its request.
    step(0, 1, 0, 0, 1, '0, '0, "one.grant");
    step(0, 1, 0, 1, 1, '0, 32'hDEAD_BEEF, "one.beat");
    step(0, 0, 0, 0, 1, '0, '0, "one.drop");
    step(0, 0, 0, 0, 1, '0, '0, "one.idle");
    chk("one.idle_owner", owner, 2'b00);

    // Stall in the middle of a requester-0 burst.
    step(1, 0, 0, 0, 1, '0, '0, "stall.grant");
    step(1, 0, 1, 0, 1, 32'hA0, '0, "stall.b1");
    step(1, 0, 1, 0, 1, 32'hA1, '0, "stall.b2");
    for (int i = 0; i < 5; i++)
      step(1, 0, 1, 0, 0, 32'hBAD0 + i, '0, "stall.hold");
    step(1, 0, 1, 0, 1, 32'hA2, '0, "stall.b3");
    step(1, 0, 1, 0, 1, 32'hA3, '0, "stall.b4");
    step(1, 0, 0, 0, 1, '0, '0, "stall.rel");

    // Requester 1 strobing while requester 0 owns the port.
    do_reset("rst3");
    step(1, 0, 0, 1, 1, '0, 32'h5555, "xena.grant");
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 1, 1, 32'h100 + i, 32'h5555, "xena");

    // Reset during an OWN1 burst after one beat.
    do_reset("rst4");
    step(0, 1, 0, 0, 1, '0, '0, "mid.grant");
    step(0, 1, 0, 1, 1, '0, 32'h77, "mid.b1");
    req0 = 1'b1;
    do_reset("mid.rst");
    step(1, 1, 0, 0, 1, '0, '0, "mid.tie");
    step(1, 1, 1, 1, 1, 32'h88, 32'h99, "mid.first");
    chk("mid.owner0", owner, 2'b01);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
           $urandom, $urandom, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
